// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } sched_state_e;

  localparam int DATA_W_DEF = 8;

  // Gap counter covers GAP_CYCLES up to 65536, timeout counter LOAD_TIMEOUT up to 65536.
  localparam int GAP_CNT_W = 16;
  localparam int TO_CNT_W  = 16;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request strictly after
// the pointer wins, wrapping at NUM_CH.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  localparam logic [IDX_W:0] NUM_CH_W = (IDX_W+1)'(NUM_CH);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk offsets 1..NUM_CH from the pointer and keep the first requester found.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= NUM_CH_W) begin
        sum = sum - NUM_CH_W;
      end
      cand = sum[IDX_W-1:0];
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_CH byte producers with round-robin
// arbitration, a req/ack handshake and a minimum idle gap between frames.
// Optional feature: define UART_TX_SCHED_TIMEOUT_EN to abandon a load whose
// transmitter never reports busy within LOAD_TIMEOUT cycles (sets sticky err_o).
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int GAP_CYCLES   = 16,
  parameter int LOAD_TIMEOUT = 65535,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic [DATA_W-1:0]        tx_data_o,
  output logic                     tx_load_o,
  input  logic                     tx_busy_i,
  output logic [IDX_W-1:0]         active_ch_o,
  output logic                     sched_busy_o,
  output logic                     err_o
);

  sched_state_e         state_q, state_d;
  logic                 busy_meta_q, busy_s_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     active_ch_q, active_ch_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic [NUM_CH-1:0]    ack_q, ack_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0]    grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic                 err_q, err_d;
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (grant_oh),
    .idx_o   (grant_idx),
    .valid_o (grant_valid)
  );

  // Bring the baud-domain busy flag into clk through two flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
    end else begin
      busy_meta_q <= tx_busy_i;
      busy_s_q    <= busy_meta_q;
    end
  end

  // Next-state logic: grant in IDLE, hold load until busy, wait frame end, then gap.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    active_ch_d = active_ch_q;
    tx_data_d   = tx_data_q;
    ack_d       = '0;
    gap_cnt_d   = gap_cnt_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_valid && !busy_s_q) begin
          state_d     = LOAD;
          tx_data_d   = data_i[grant_idx*DATA_W +: DATA_W];
          active_ch_d = grant_idx;
          ptr_d       = grant_idx;
          ack_d       = grant_oh;
`ifdef UART_TX_SCHED_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end
      LOAD: begin
        if (busy_s_q) begin
          state_d = SEND;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (to_cnt_q == TO_CNT_W'(LOAD_TIMEOUT-1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      SEND: begin
        if (!busy_s_q) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_CNT_W'(GAP_CYCLES-1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state register; pointer resets to the last channel so channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_CH-1);
      active_ch_q <= '0;
      tx_data_q   <= '0;
      ack_q       <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      active_ch_q <= active_ch_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  // Load timeout counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign ack_o        = ack_q;
  assign tx_data_o    = tx_data_q;
  assign tx_load_o    = (state_q == LOAD);
  assign active_ch_o  = active_ch_q;
  assign sched_busy_o = (state_q != IDLE);

endmodule
